mem_arbiter: RTL

- Sits directly downstream of the request unit and the datapath's instruction-fetch port.
- Takes the registered data strobes (dmemren/dmemwen) and the instruction fetch request, and arbitrates them onto a single-ported, variable-latency RAM.
- Returns ihit/dhit back to the request unit and datapath.
- Implemented as a multi-cycle FSM with one outstanding RAM access at a time, round-robin arbitration, and a timeout watchdog.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the request side (instruction fetch + data strobes), the hit/return
// side and the single-ported RAM side of the memory arbiter.
//   slave  : the arbiter's view (takes requests and RAM returns, drives hits
//            and RAM strobes)
//   master : the environment's view (request unit, datapath and RAM together)
// Signals:
//   iREN/iaddr                   instruction fetch request and address
//   dREN/dWEN/daddr/dstore       data read/write request, address, store data
//   ihit/dhit/iload/dload/err    completion pulses, returned data, timeout flag
//   ramREN/ramWEN/ramaddr/ramstore  RAM strobes, address and write data
//   ramload/ram_ready            RAM read data and one-cycle completion
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32
);
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic              dREN;
   logic              dWEN;
   logic [ADDR_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              ihit;
   logic              dhit;
   logic [WORD_W-1:0] iload;
   logic [WORD_W-1:0] dload;
   logic              err;
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   logic              ram_ready;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
      output ihit, dhit, iload, dload, err, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
      input  ihit, dhit, iload, dload, err, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates instruction fetches and data loads/stores onto one single-ported,
// variable-latency RAM. One access is outstanding at a time; conflicting
// requests are granted round-robin, and an access that sees no ram_ready for
// TIMEOUT cycles is aborted and reported through err alongside its hit.
// Ports:
//   CLK  - system clock, all state on the rising edge
//   RST  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave (requests, hits, returned data, RAM side)
// All outputs are registered. RAM strobes are computed from the next state so
// that they line up exactly with the IACC/DACC states.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int WORD_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          CLK,
   input  logic          RST,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IACC = 2'd1,
      DACC = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   // last_grant encoding: 0 = instruction, 1 = data
   localparam logic GRANT_INSTR = 1'b0;

   state_t            state_r;
   state_t            next_state_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              last_grant_r;
   logic              sel_data_r;
   logic              op_wr_r;
   logic [ADDR_W-1:0] addr_r;
   logic [WORD_W-1:0] store_r;
   logic [WORD_W-1:0] iload_r;
   logic [WORD_W-1:0] dload_r;
   logic              ihit_r;
   logic              dhit_r;
   logic              err_r;
   logic              ramren_r;
   logic              ramwen_r;

   logic              data_pend_s;
   logic              grant_s;
   logic              grant_data_s;
   logic              capture_s;
   logic              timeout_s;
   logic              next_wr_s;
   logic              next_sel_data_s;
   logic              ramren_next_s;
   logic              ramwen_next_s;
   logic              ihit_next_s;
   logic              dhit_next_s;

   // Next-state, grant decision and next values of the registered outputs
   always_comb begin
      next_state_s = state_r;
      grant_s      = 1'b0;
      grant_data_s = 1'b0;
      capture_s    = 1'b0;
      timeout_s    = 1'b0;
      data_pend_s  = bus.dREN | bus.dWEN;

      case (state_r)
         IDLE: begin
            grant_s = data_pend_s | bus.iREN;
            if (data_pend_s && bus.iREN) begin
               // conflict: the side that did not win last time goes now
               grant_data_s = (last_grant_r == GRANT_INSTR);
            end else begin
               grant_data_s = data_pend_s;
            end
            if (grant_s) begin
               next_state_s = grant_data_s ? DACC : IACC;
            end else begin
               next_state_s = IDLE;
            end
         end
         IACC, DACC: begin
            if (bus.ram_ready) begin
               capture_s    = 1'b1;
               next_state_s = RESP;
            end else if (cnt_r == CNT_LAST) begin
               timeout_s    = 1'b1;
               next_state_s = RESP;
            end else begin
               next_state_s = state_r;
            end
         end
         RESP: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase

      // a simultaneous read+write request is carried out as a write
      next_wr_s       = grant_s ? (grant_data_s & bus.dWEN) : op_wr_r;
      next_sel_data_s = grant_s ? grant_data_s : sel_data_r;
      ramren_next_s   = (next_state_s == IACC) |
                        ((next_state_s == DACC) & ~next_wr_s);
      ramwen_next_s   = (next_state_s == DACC) & next_wr_s;
      ihit_next_s     = (next_state_s == RESP) & ~next_sel_data_s;
      dhit_next_s     = (next_state_s == RESP) & next_sel_data_s;
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Grant latches, access counter and captured load data
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_r        <= '0;
         last_grant_r <= GRANT_INSTR;
         sel_data_r   <= 1'b0;
         op_wr_r      <= 1'b0;
         addr_r       <= '0;
         store_r      <= '0;
         iload_r      <= '0;
         dload_r      <= '0;
      end else begin
         if (grant_s) begin
            cnt_r        <= '0;
            last_grant_r <= grant_data_s;
            sel_data_r   <= grant_data_s;
            op_wr_r      <= next_wr_s;
            if (grant_data_s) begin
               addr_r  <= bus.daddr;
               store_r <= bus.dstore;
            end else begin
               addr_r  <= bus.iaddr;
            end
         end else if ((state_r == IACC || state_r == DACC) && cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (capture_s) begin
            if (!sel_data_r) begin
               iload_r <= bus.ramload;
            end else if (!op_wr_r) begin
               dload_r <= bus.ramload;
            end
         end
      end
   end

   // Registered hit, error and RAM strobe outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         ihit_r   <= 1'b0;
         dhit_r   <= 1'b0;
         err_r    <= 1'b0;
         ramren_r <= 1'b0;
         ramwen_r <= 1'b0;
      end else begin
         ihit_r   <= ihit_next_s;
         dhit_r   <= dhit_next_s;
         err_r    <= timeout_s;
         ramren_r <= ramren_next_s;
         ramwen_r <= ramwen_next_s;
      end
   end

   assign bus.ihit     = ihit_r;
   assign bus.dhit     = dhit_r;
   assign bus.err      = err_r;
   assign bus.iload    = iload_r;
   assign bus.dload    = dload_r;
   assign bus.ramREN   = ramren_r;
   assign bus.ramWEN   = ramwen_r;
   assign bus.ramaddr  = addr_r;
   assign bus.ramstore = store_r;

endmodule
